// File: rtl/bus_arbiter.sv
// Two-port Wishbone arbiter: a fetch port (s1) and a load/store port (s2) share one
// pipelined master bus, with round-robin tie breaking and an outstanding-request limit.
module bus_arbiter #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] s1_wb_adr_i,
   input  logic [31:0] s1_wb_dat_i,
   output logic [31:0] s1_wb_dat_o,
   input  logic        s1_wb_we_i,
   input  logic [3:0]  s1_wb_sel_i,
   input  logic        s1_wb_stb_i,
   output logic        s1_wb_ack_o,
   input  logic        s1_wb_cyc_i,
   output logic        s1_wb_stall_o,
   input  logic [31:0] s2_wb_adr_i,
   input  logic [31:0] s2_wb_dat_i,
   output logic [31:0] s2_wb_dat_o,
   input  logic        s2_wb_we_i,
   input  logic [3:0]  s2_wb_sel_i,
   input  logic        s2_wb_stb_i,
   output logic        s2_wb_ack_o,
   input  logic        s2_wb_cyc_i,
   output logic        s2_wb_stall_o,
   output logic [31:0] m_wb_adr_o,
   output logic [31:0] m_wb_dat_o,
   output logic        m_wb_we_o,
   output logic [3:0]  m_wb_sel_o,
   output logic        m_wb_stb_o,
   output logic        m_wb_cyc_o,
   input  logic [31:0] m_wb_dat_i,
   input  logic        m_wb_ack_i,
   input  logic        m_wb_stall_i
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN_S1 = 2'd1,
      OWN_S2 = 2'd2
   } state_t;

   localparam logic       OWNER_S1 = 1'b0;
   localparam logic       OWNER_S2 = 1'b1;
   localparam logic [3:0] MAX_OUT  = 4'(MAX_OUTSTANDING);

   state_t     state_r;
   logic       last_owner_r;
   logic [3:0] outstanding_r;
   logic [3:0] outstanding_next_s;
   logic       limit_s;
   logic       accept_s;

   // Read data is broadcast; only the owner's ack qualifies it.
   assign s1_wb_dat_o = m_wb_dat_i;
   assign s2_wb_dat_o = m_wb_dat_i;

   // Master-bus mux and requester handshakes, selected by the current owner.
   always_comb begin
      m_wb_adr_o    = 32'd0;
      m_wb_dat_o    = 32'd0;
      m_wb_we_o     = 1'b0;
      m_wb_sel_o    = 4'd0;
      m_wb_stb_o    = 1'b0;
      m_wb_cyc_o    = 1'b0;
      s1_wb_stall_o = 1'b1;
      s2_wb_stall_o = 1'b1;
      s1_wb_ack_o   = 1'b0;
      s2_wb_ack_o   = 1'b0;
      limit_s       = (outstanding_r == MAX_OUT);
      case (state_r)
         OWN_S1: begin
            m_wb_adr_o    = s1_wb_adr_i;
            m_wb_dat_o    = s1_wb_dat_i;
            m_wb_we_o     = s1_wb_we_i;
            m_wb_sel_o    = s1_wb_sel_i;
            m_wb_cyc_o    = s1_wb_cyc_i;
            m_wb_stb_o    = s1_wb_stb_i & ~limit_s;
            s1_wb_stall_o = m_wb_stall_i | limit_s;
            s1_wb_ack_o   = m_wb_ack_i;
         end
         OWN_S2: begin
            m_wb_adr_o    = s2_wb_adr_i;
            m_wb_dat_o    = s2_wb_dat_i;
            m_wb_we_o     = s2_wb_we_i;
            m_wb_sel_o    = s2_wb_sel_i;
            m_wb_cyc_o    = s2_wb_cyc_i;
            m_wb_stb_o    = s2_wb_stb_i & ~limit_s;
            s2_wb_stall_o = m_wb_stall_i | limit_s;
            s2_wb_ack_o   = m_wb_ack_i;
         end
         default: begin
            m_wb_cyc_o = 1'b0;
         end
      endcase
   end

   // Outstanding count: accept and ack in the same cycle cancel; saturates at 0 and the limit.
   always_comb begin
      accept_s           = m_wb_stb_o & ~m_wb_stall_i;
      outstanding_next_s = outstanding_r;
      if (accept_s && !m_wb_ack_i && (outstanding_r < MAX_OUT)) begin
         outstanding_next_s = outstanding_r + 4'd1;
      end else if (!accept_s && m_wb_ack_i && (outstanding_r != 4'd0)) begin
         outstanding_next_s = outstanding_r - 4'd1;
      end else begin
         outstanding_next_s = outstanding_r;
      end
   end

   // Ownership FSM; dropping cyc always releases the bus and abandons any outstanding requests.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r       <= IDLE;
         outstanding_r <= 4'd0;
         last_owner_r  <= OWNER_S2;
      end else begin
         case (state_r)
            IDLE: begin
               outstanding_r <= 4'd0;
               if (s1_wb_cyc_i && s2_wb_cyc_i) begin
                  if (last_owner_r == OWNER_S2) begin
                     state_r      <= OWN_S1;
                     last_owner_r <= OWNER_S1;
                  end else begin
                     state_r      <= OWN_S2;
                     last_owner_r <= OWNER_S2;
                  end
               end else if (s1_wb_cyc_i) begin
                  state_r      <= OWN_S1;
                  last_owner_r <= OWNER_S1;
               end else if (s2_wb_cyc_i) begin
                  state_r      <= OWN_S2;
                  last_owner_r <= OWNER_S2;
               end else begin
                  state_r <= IDLE;
               end
            end
            OWN_S1: begin
               if (!s1_wb_cyc_i) begin
                  state_r       <= IDLE;
                  outstanding_r <= 4'd0;
               end else begin
                  outstanding_r <= outstanding_next_s;
               end
            end
            OWN_S2: begin
               if (!s2_wb_cyc_i) begin
                  state_r       <= IDLE;
                  outstanding_r <= 4'd0;
               end else begin
                  outstanding_r <= outstanding_next_s;
               end
            end
            default: begin
               state_r       <= IDLE;
               outstanding_r <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected master accepts and requester acks are queued by
// the stimulus and consumed by a monitor; cycle-level handshake values are checked inline.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s1_adr = 32'd0, s1_dat = 32'd0, s2_adr = 32'd0, s2_dat = 32'd0;
   logic        s1_we = 1'b0, s2_we = 1'b0;
   logic [3:0]  s1_sel = 4'hF, s2_sel = 4'hF;
   logic        s1_stb = 1'b0, s2_stb = 1'b0, s1_cyc = 1'b0, s2_cyc = 1'b0;
   logic [31:0] s1_dat_o, s2_dat_o;
   logic        s1_ack, s2_ack, s1_stall, s2_stall;
   logic [31:0] m_adr, m_dat_o, m_dat_i = 32'd0;
   logic        m_we, m_stb, m_cyc;
   logic [3:0]  m_sel;
   logic        m_ack = 1'b0, m_stall = 1'b0;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
      logic [3:0]  sel;
   } acc_t;
   typedef struct {
      int          port;
      logic [31:0] dat;
   } ack_t;

   acc_t        acc_q[$];
   ack_t        ack_q[$];
   acc_t        mon_acc;
   ack_t        mon_ack;
   int          mon_port;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] dat_seq = 32'hD000_0000;

   bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .s1_wb_adr_i(s1_adr), .s1_wb_dat_i(s1_dat), .s1_wb_dat_o(s1_dat_o), .s1_wb_we_i(s1_we),
      .s1_wb_sel_i(s1_sel), .s1_wb_stb_i(s1_stb), .s1_wb_ack_o(s1_ack), .s1_wb_cyc_i(s1_cyc),
      .s1_wb_stall_o(s1_stall),
      .s2_wb_adr_i(s2_adr), .s2_wb_dat_i(s2_dat), .s2_wb_dat_o(s2_dat_o), .s2_wb_we_i(s2_we),
      .s2_wb_sel_i(s2_sel), .s2_wb_stb_i(s2_stb), .s2_wb_ack_o(s2_ack), .s2_wb_cyc_i(s2_cyc),
      .s2_wb_stall_o(s2_stall),
      .m_wb_adr_o(m_adr), .m_wb_dat_o(m_dat_o), .m_wb_we_o(m_we), .m_wb_sel_o(m_sel),
      .m_wb_stb_o(m_stb), .m_wb_cyc_o(m_cyc), .m_wb_dat_i(m_dat_i), .m_wb_ack_i(m_ack),
      .m_wb_stall_i(m_stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_acc(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel);
      acc_t e;
      e.adr = adr; e.we = we; e.dat = dat; e.sel = sel;
      acc_q.push_back(e);
   endtask

   // One acked cycle per iteration, each carrying fresh read data for the given port.
   task automatic acks(input int port, input int n);
      ack_t e;
      for (int k = 0; k < n; k++) begin
         m_ack   = 1'b1;
         m_dat_i = dat_seq;
         e.port  = port;
         e.dat   = dat_seq;
         ack_q.push_back(e);
         dat_seq = dat_seq + 32'd1;
         at_neg();
         tick();
      end
      m_ack = 1'b0;
   endtask

   // S1 streams n strobes holding a stalled address; only the first nacc may be accepted.
   task automatic burst1(input logic [31:0] base, input int n, input int nacc);
      for (int k = 0; k < n; k++) begin
         s1_stb = 1'b1;
         s1_adr = base + 32'((k < nacc) ? k : nacc);
         if (k < nacc) push_acc(s1_adr, 1'b0, 32'd0, 4'hF);
         at_neg();
         chk1("burst_m_stb", m_stb, k < nacc);
         chk1("burst_s1_stall", s1_stall, k >= nacc);
         tick();
      end
      s1_stb = 1'b0;
   endtask

   // Monitor: every master accept and every requester ack must match the next queued entry.
   always @(negedge clk) begin
      if (m_stb && !m_stall) begin
         checks++;
         if (acc_q.size() == 0) begin
            errors++;
            $display("FAIL accept_unexpected: got adr %h expected no accept at %0t", m_adr, $time);
         end else begin
            mon_acc = acc_q.pop_front();
            if (m_adr !== mon_acc.adr || m_we !== mon_acc.we || m_dat_o !== mon_acc.dat ||
                m_sel !== mon_acc.sel) begin
               errors++;
               $display("FAIL accept: got adr %h we %b dat %h sel %h expected adr %h we %b dat %h sel %h",
                        m_adr, m_we, m_dat_o, m_sel, mon_acc.adr, mon_acc.we, mon_acc.dat, mon_acc.sel);
            end
         end
      end
      if (s1_ack || s2_ack) begin
         checks++;
         mon_port = (s1_ack && s2_ack) ? 3 : (s1_ack ? 1 : 2);
         if (ack_q.size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected: got ack on port %0d expected none at %0t", mon_port, $time);
         end else begin
            mon_ack = ack_q.pop_front();
            if (mon_port != mon_ack.port || s1_dat_o !== mon_ack.dat || s2_dat_o !== mon_ack.dat) begin
               errors++;
               $display("FAIL ack: got port %0d dat %h/%h expected port %0d dat %h",
                        mon_port, s1_dat_o, s2_dat_o, mon_ack.port, mon_ack.dat);
            end
         end
      end
   end

   initial begin
      repeat (5000) @(posedge clk);
      $display("FAIL watchdog: got no completion expected finish within 5000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      at_neg();
      chk1("rst_m_cyc", m_cyc, 1'b0);
      chk1("rst_m_stb", m_stb, 1'b0);
      chk1("rst_s1_stall", s1_stall, 1'b1);
      chk1("rst_s2_stall", s2_stall, 1'b1);
      chk1("rst_s1_ack", s1_ack, 1'b0);
      chk1("rst_s2_ack", s2_ack, 1'b0);
      tick();
      tick();
      rst = 1'b0;

      // tie at cycle 0: S1 wins, releases at 4, IDLE at 5, S2 owns at 6
      s1_cyc = 1'b1; s2_cyc = 1'b1; s1_adr = 32'h10;
      at_neg();
      chk1("tie_c0_m_cyc", m_cyc, 1'b0);
      chk1("tie_c0_s1_stall", s1_stall, 1'b1);
      tick();
      s1_stb = 1'b1;
      push_acc(32'h10, 1'b0, 32'd0, 4'hF);
      at_neg();
      chk1("tie_c1_m_cyc", m_cyc, 1'b1);
      chk1("tie_c1_s1_stall", s1_stall, 1'b0);
      chk1("tie_c1_s2_stall", s2_stall, 1'b1);
      chk32("tie_c1_m_adr", m_adr, 32'h10);
      tick();
      s1_stb = 1'b0;
      acks(1, 1);
      at_neg();
      tick();
      s1_cyc = 1'b0;
      at_neg();
      chk1("tie_c4_s2_stall", s2_stall, 1'b1);
      tick();
      at_neg();
      chk1("tie_c5_m_cyc", m_cyc, 1'b0);
      chk1("tie_c5_s2_stall", s2_stall, 1'b1);
      tick();
      at_neg();
      chk1("tie_c6_m_cyc", m_cyc, 1'b1);
      chk1("tie_c6_s2_stall", s2_stall, 1'b0);
      chk1("tie_c6_s1_stall", s1_stall, 1'b1);
      tick();
      s2_cyc = 1'b0;
      at_neg();
      tick();

      // isolation while S2 owns, then abort with one request outstanding
      s2_cyc = 1'b1; s2_adr = 32'h200; s2_we = 1'b1; s2_dat = 32'h55; s2_sel = 4'h3;
      at_neg();
      tick();
      s2_stb = 1'b1; s1_cyc = 1'b1; s1_stb = 1'b1; s1_adr = 32'h100;
      push_acc(32'h200, 1'b1, 32'h55, 4'h3);
      at_neg();
      chk1("iso_s1_stall", s1_stall, 1'b1);
      chk1("iso_s1_ack", s1_ack, 1'b0);
      chk32("iso_m_adr", m_adr, 32'h200);
      chk1("iso_s2_stall", s2_stall, 1'b0);
      tick();
      s2_stb = 1'b0; s1_cyc = 1'b0; s1_stb = 1'b0; s2_cyc = 1'b0;
      at_neg();
      tick();
      m_ack = 1'b1; m_dat_i = 32'hBAD0_0001;
      at_neg();
      chk1("abort_m_cyc", m_cyc, 1'b0);
      chk1("abort_s1_ack", s1_ack, 1'b0);
      chk1("abort_s2_ack", s2_ack, 1'b0);
      tick();
      m_ack = 1'b0; s2_we = 1'b0; s2_sel = 4'hF;

      // outstanding limit, simultaneous accept+ack, ack at zero
      s1_cyc = 1'b1;
      at_neg();
      tick();
      burst1(32'h1000, 6, 4);
      s1_stb = 1'b1; s1_adr = 32'h1004;
      m_ack = 1'b1; m_dat_i = 32'hC000_0001;
      ack_q.push_back('{port: 1, dat: 32'hC000_0001});
      at_neg();
      chk1("lim_ack_m_stb", m_stb, 1'b0);
      chk1("lim_ack_s1_stall", s1_stall, 1'b1);
      tick();
      m_ack = 1'b0;
      push_acc(32'h1004, 1'b0, 32'd0, 4'hF);
      at_neg();
      chk1("lim_one_more_m_stb", m_stb, 1'b1);
      tick();
      s1_adr = 32'h1005;
      at_neg();
      chk1("lim_full_again_m_stb", m_stb, 1'b0);
      chk1("lim_full_again_s1_stall", s1_stall, 1'b1);
      tick();
      s1_stb = 1'b0;
      acks(1, 2);
      s1_stb = 1'b1; s1_adr = 32'h2000; m_ack = 1'b1; m_dat_i = 32'hC000_0002;
      push_acc(32'h2000, 1'b0, 32'd0, 4'hF);
      ack_q.push_back('{port: 1, dat: 32'hC000_0002});
      at_neg();
      tick();
      m_ack = 1'b0;
      burst1(32'h2001, 3, 2);
      acks(1, 4);
      acks(1, 1);
      burst1(32'h3000, 5, 4);
      acks(1, 4);
      s1_cyc = 1'b0;
      at_neg();
      tick();
      at_neg();
      chk1("release_m_cyc", m_cyc, 1'b0);
      tick();

      // reset mid-burst with S1 owning and one request outstanding
      s1_cyc = 1'b1;
      at_neg();
      tick();
      s1_stb = 1'b1; s1_adr = 32'h4000;
      push_acc(32'h4000, 1'b0, 32'd0, 4'hF);
      at_neg();
      tick();
      s1_stb = 1'b0;
      rst = 1'b1; m_ack = 1'b1; m_dat_i = 32'hBAD0_0002;
      #1;
      chk1("midrst_m_cyc", m_cyc, 1'b0);
      chk1("midrst_s1_stall", s1_stall, 1'b1);
      chk1("midrst_s2_stall", s2_stall, 1'b1);
      chk1("midrst_s1_ack", s1_ack, 1'b0);
      tick();
      rst = 1'b0; s2_cyc = 1'b1;
      at_neg();
      chk1("postrst_s1_ack", s1_ack, 1'b0);
      chk1("postrst_m_cyc", m_cyc, 1'b0);
      tick();
      m_ack = 1'b0;
      at_neg();
      chk1("postrst_tie_m_cyc", m_cyc, 1'b1);
      chk1("postrst_tie_s1_stall", s1_stall, 1'b0);
      chk1("postrst_tie_s2_stall", s2_stall, 1'b1);
      chk32("postrst_tie_m_adr", m_adr, 32'h4000);
      tick();
      s1_cyc = 1'b0; s2_cyc = 1'b0;
      at_neg();
      tick();
      at_neg();

      chk32("acc_queue_drained", 32'(acc_q.size()), 32'd0);
      chk32("ack_queue_drained", 32'(ack_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4: maximum accepted-but-unacknowledged requests on the master bus, range 1..15.
REQ-002 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports s1_wb_adr_i, s2_wb_adr_i  in  32  requester addresses (s1 = fetch, s2 = loadstore).
REQ-005 SHALL have ports s1_wb_dat_i, s2_wb_dat_i  in  32  requester write data.
REQ-006 SHALL have ports s1_wb_dat_o, s2_wb_dat_o  out  32  read data returned to the requesters.
REQ-007 SHALL have ports s1_wb_we_i, s2_wb_we_i  in  1  write enable.
REQ-008 SHALL have ports s1_wb_sel_i, s2_wb_sel_i  in  4  byte selects.
REQ-009 SHALL have ports s1_wb_stb_i, s2_wb_stb_i  in  1  request strobe.
REQ-010 SHALL have ports s1_wb_ack_o, s2_wb_ack_o  out  1  acknowledge.
REQ-011 SHALL have ports s1_wb_cyc_i, s2_wb_cyc_i  in  1  bus cycle request.
REQ-012 SHALL have ports s1_wb_stall_o, s2_wb_stall_o  out  1  stall.
REQ-013 SHALL have ports m_wb_adr_o 32, m_wb_dat_o 32, m_wb_we_o 1, m_wb_sel_o 4, m_wb_stb_o 1, m_wb_cyc_o 1  out  pipelined Wishbone master outputs.
REQ-014 SHALL have ports m_wb_dat_i 32, m_wb_ack_i 1, m_wb_stall_i 1  in  master bus responses.

Function
REQ-015 SHALL implement the states IDLE, OWN_S1 and OWN_S2, plus a 1-bit last_owner register and a 4-bit outstanding counter.
REQ-016 In IDLE, with exactly one sx_wb_cyc_i high, SHALL enter OWN_Sx on the next edge; arbitration latency is one cycle.
REQ-017 In IDLE, with both cyc inputs high, SHALL grant the port that is not last_owner (round-robin) and update last_owner on entry to OWN_Sx.
REQ-018 In IDLE, SHALL drive m_wb_cyc_o=0, m_wb_stb_o=0, both sx_wb_stall_o=1 and both sx_wb_ack_o=0.
REQ-019 In OWN_Sx, SHALL drive m_wb_adr/dat/we/sel/cyc_o combinationally from port x.
REQ-020 In OWN_Sx, SHALL drive m_wb_stb_o = sx_wb_stb_i & ~limit, with limit = (outstanding == MAX_OUTSTANDING).
REQ-021 In OWN_Sx, SHALL drive sx_wb_stall_o = m_wb_stall_i | limit and sx_wb_ack_o = m_wb_ack_i.
REQ-022 In OWN_Sx, the non-owner SHALL see stall=1 and ack=0.
REQ-023 SHALL broadcast m_wb_dat_i to both s1_wb_dat_o and s2_wb_dat_o unregistered.
REQ-024 outstanding SHALL update as follows:
- +1 on accept (m_wb_stb_o & ~m_wb_stall_i)
- -1 on m_wb_ack_i
- unchanged when both occur in the same cycle
- never decrements below 0 (an ack at 0 is ignored)
- never exceeds MAX_OUTSTANDING
REQ-025 In OWN_Sx, when sx_wb_cyc_i=0 and outstanding=0, SHALL return to IDLE on the next edge; re-grant SHALL take at least one IDLE cycle.
REQ-026 If the owner drops cyc with outstanding>0 (abort), SHALL:
- go to IDLE on the next edge
- clear outstanding
- drop later acks (ack_o stays 0 in IDLE)
REQ-027 SHALL never change owner while the owner's cyc is high, even if the other port is requesting.

Reset
REQ-028 While rst_i is high, the block SHALL force asynchronously: state=IDLE, outstanding=0, last_owner=S2 (so S1 wins the first tie), m_wb_cyc_o=0, m_wb_stb_o=0, both stall=1, both ack=0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction; no ack SHALL be forwarded after reset releases until a new grant.

Verification
REQ-030 Bench SHALL cover the tie: both cyc rise at cycle 0 after reset -> OWN_S1 at cycle 1; S1 releases at cycle 4 -> IDLE at cycle 5, OWN_S2 at cycle 6.
REQ-031 Bench SHALL cover the limit: S1 issues 6 back-to-back stb, m_wb_stall_i=0, no acks, MAX_OUTSTANDING=4 -> 4 accepted, then s1_wb_stall_o=1 and m_wb_stb_o=0; one ack -> exactly one more accepted.
REQ-032 Bench SHALL cover simultaneous accept and ack with outstanding=2 -> outstanding stays 2; ack at outstanding=0 -> stays 0.
REQ-033 Bench SHALL cover isolation: while S2 owns, S1 raises cyc/stb with adr=0x100 -> s1_wb_stall_o=1, s1_wb_ack_o=0, m_wb_adr_o equals S2 address.
REQ-034 Bench SHALL cover abort: S2 drops cyc with outstanding=1 -> IDLE next cycle, a later m_wb_ack_i produces no sx_wb_ack_o.
REQ-035 Bench SHALL cover reset mid-burst: rst_i asserted during OWN_S1 -> same-cycle m_wb_cyc_o=0 and both stall=1; after release the first tie goes to S1.
